// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the LEGv8 multi-cycle sequencer: states, opcode classes,
// opcode match patterns and ALU operation codes.
package arm_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    CL_ILLEGAL = 3'd0,
    CL_R       = 3'd1,
    CL_LDUR    = 3'd2,
    CL_STUR    = 3'd3,
    CL_CBZ     = 3'd4,
    CL_B       = 3'd5
  } class_t;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  // CBZ keys on opcode[10:3]=0xB4, B on opcode[10:5]=0x05
  localparam logic [10:0] MASK_CBZ  = 11'h7F8;
  localparam logic [10:0] MATCH_CBZ = 11'h5A0;
  localparam logic [10:0] MASK_B    = 11'h7E0;
  localparam logic [10:0] MATCH_B   = 11'h0A0;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  function automatic logic op_match(input logic [10:0] opc,
                                    input logic [10:0] mask,
                                    input logic [10:0] pattern);
    return ((opc & mask) == pattern);
  endfunction

endpackage

// File: rtl/arm_opcode_class.sv
// Combinational opcode[10:0] to instruction-class decoder, shared with ALU control
// so both blocks agree on what each opcode means.
module arm_opcode_class
  import arm_ctrl_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  op_class
);

  class_t w_class;

  // Exact-match opcodes first, then the masked branch families
  always_comb begin
    w_class = CL_ILLEGAL;
    if ((opcode == OP_ADD) || (opcode == OP_SUB) ||
        (opcode == OP_AND) || (opcode == OP_ORR)) begin
      w_class = CL_R;
    end else if (opcode == OP_LDUR) begin
      w_class = CL_LDUR;
    end else if (opcode == OP_STUR) begin
      w_class = CL_STUR;
    end else if (op_match(opcode, MASK_CBZ, MATCH_CBZ)) begin
      w_class = CL_CBZ;
    end else if (op_match(opcode, MASK_B, MATCH_B)) begin
      w_class = CL_B;
    end else begin
      w_class = CL_ILLEGAL;
    end
  end

  assign op_class = w_class;

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multi-cycle LEGv8 control sequencer: steps each instruction through
// fetch/decode/execute/memory/write-back over a unified ready-handshake memory.
module arm_multicycle_ctrl
  import arm_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             pc_reset_n,
  input  logic [10:0]      opcode,
  input  logic             zero_alu,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_to_loc,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] retired
);

  state_t           r_state;
  class_t           r_class;
  logic [CNT_W-1:0] r_retired;
  logic [2:0]       w_class_raw;
  class_t           w_class;
  logic             w_retire;

  arm_opcode_class u_class (
    .opcode   (opcode),
    .op_class (w_class_raw)
  );

  assign w_class = class_t'(w_class_raw);

  // An instruction retires on the last cycle of its sequence
  always_comb begin
    w_retire = 1'b0;
    case (r_state)
      ST_EXEC: w_retire = (r_class == CL_CBZ) || (r_class == CL_B);
      ST_MEM:  w_retire = (r_class == CL_STUR) && mem_ready;
      ST_WB:   w_retire = 1'b1;
      default: w_retire = 1'b0;
    endcase
  end

  // Sequencer state, latched instruction class and retired counter
  always_ff @(posedge clk or negedge pc_reset_n) begin
    if (!pc_reset_n) begin
      r_state   <= ST_IDLE;
      r_class   <= CL_ILLEGAL;
      r_retired <= {CNT_W{1'b0}};
    end else begin
      if (w_retire) begin
        r_retired <= r_retired + CNT_W'(1);
      end
      case (r_state)
        ST_IDLE: r_state <= ST_FETCH;
        ST_FETCH: begin
          if (mem_ready) r_state <= ST_DECODE;
          else           r_state <= ST_FETCH;
        end
        ST_DECODE: begin
          r_class <= w_class;
          if (w_class == CL_ILLEGAL) r_state <= ST_FETCH;
          else                       r_state <= ST_EXEC;
        end
        ST_EXEC: begin
          case (r_class)
            CL_R:            r_state <= ST_WB;
            CL_LDUR, CL_STUR: r_state <= ST_MEM;
            default:         r_state <= ST_FETCH;
          endcase
        end
        ST_MEM: begin
          if (!mem_ready)              r_state <= ST_MEM;
          else if (r_class == CL_STUR) r_state <= ST_FETCH;
          else                         r_state <= ST_WB;
        end
        ST_WB:   r_state <= ST_FETCH;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Datapath strobes; memory requests stay up until the handshake completes
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_to_loc = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALUOP_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
        end
      end
      ST_DECODE: illegal = (w_class == CL_ILLEGAL);
      ST_EXEC: begin
        case (r_class)
          CL_R: alu_op = ALUOP_FUNCT;
          CL_LDUR, CL_STUR: alu_src = 1'b1;
          CL_CBZ: begin
            reg_to_loc = 1'b1;
            alu_op     = ALUOP_PASSB;
            if (zero_alu) begin
              pc_write = 1'b1;
              pc_src   = 1'b1;
            end else begin
              pc_write = 1'b0;
            end
          end
          CL_B: begin
            pc_write = 1'b1;
            pc_src   = 1'b1;
          end
          default: alu_op = ALUOP_ADD;
        endcase
      end
      ST_MEM: begin
        iord    = 1'b1;
        alu_src = 1'b1;
        if (r_class == CL_STUR) begin
          mem_write  = 1'b1;
          reg_to_loc = 1'b1;
        end else begin
          mem_read = 1'b1;
        end
      end
      ST_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = (r_class == CL_LDUR);
      end
      default: illegal = 1'b0;
    endcase
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Randomized bench for arm_multicycle_ctrl against an instruction-level phase model.
module tb_arm_multicycle_ctrl;
  import arm_ctrl_pkg::*;

  localparam int CW = 8;
  localparam int K_ILL = 0, K_R = 1, K_LD = 2, K_ST = 3, K_CBZ = 4, K_B = 5;
  localparam int P_IDLE = 0, P_FETCH = 1, P_DECODE = 2, P_EXEC = 3, P_MEM = 4, P_WB = 5;

  logic          clk = 1'b0;
  logic          pc_reset_n;
  logic [10:0]   opcode;
  logic          zero_alu, mem_ready;
  logic          pc_write, pc_src, ir_write, iord, mem_read, mem_write;
  logic          reg_to_loc, alu_src, mem_to_reg, reg_write, illegal;
  logic [1:0]    alu_op;
  logic [2:0]    state;
  logic [CW-1:0] retired;

  int total = 0;
  int bad   = 0;
  int exp_ret = 0;

  arm_multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .pc_reset_n(pc_reset_n), .opcode(opcode), .zero_alu(zero_alu),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .reg_to_loc(reg_to_loc),
    .alu_src(alu_src), .alu_op(alu_op), .mem_to_reg(mem_to_reg), .reg_write(reg_write),
    .illegal(illegal), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int classify(input logic [10:0] o);
    if (o == 11'h458 || o == 11'h658 || o == 11'h450 || o == 11'h550) return K_R;
    if (o == 11'h7C2) return K_LD;
    if (o == 11'h7C0) return K_ST;
    if (o[10:3] == 8'hB4) return K_CBZ;
    if (o[10:5] == 6'h05) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [2:0] state_of(input int ph);
    case (ph)
      P_FETCH:  return ST_FETCH;
      P_DECODE: return ST_DECODE;
      P_EXEC:   return ST_EXEC;
      P_MEM:    return ST_MEM;
      P_WB:     return ST_WB;
      default:  return ST_IDLE;
    endcase
  endfunction

  // Expected {pc_write,pc_src,ir_write,iord,mem_read,mem_write,reg_to_loc,alu_src,alu_op,mem_to_reg,reg_write,illegal}
  function automatic logic [12:0] exp_strobes(input int ph, input int k, input logic rdy, input logic z);
    logic pw = 1'b0, ps = 1'b0, irw = 1'b0, io = 1'b0, mr = 1'b0, mw = 1'b0;
    logic rtl = 1'b0, as = 1'b0, m2r = 1'b0, rw = 1'b0, ill = 1'b0;
    logic [1:0] aop = 2'b00;
    case (ph)
      P_FETCH: begin mr = 1'b1; irw = rdy; pw = rdy; end
      P_DECODE: ill = (k == K_ILL);
      P_EXEC: begin
        if (k == K_R) aop = 2'b10;
        if (k == K_LD || k == K_ST) as = 1'b1;
        if (k == K_CBZ) begin rtl = 1'b1; aop = 2'b01; pw = z; ps = z; end
        if (k == K_B) begin pw = 1'b1; ps = 1'b1; end
      end
      P_MEM: begin
        io = 1'b1; as = 1'b1;
        mr = (k == K_LD); mw = (k == K_ST); rtl = (k == K_ST);
      end
      P_WB: begin rw = 1'b1; m2r = (k == K_LD); end
      default: ;
    endcase
    return {pw, ps, irw, io, mr, mw, rtl, as, aop, m2r, rw, ill};
  endfunction

  function automatic logic [12:0] obs_strobes();
    return {pc_write, pc_src, ir_write, iord, mem_read, mem_write, reg_to_loc,
            alu_src, alu_op, mem_to_reg, reg_write, illegal};
  endfunction

  // One clock cycle: drive, check at the falling edge, advance past the rising edge
  task automatic cycle(input int ph, input int k, input logic rdy, input logic z);
    mem_ready = rdy;
    zero_alu  = z;
    @(negedge clk);
    check_val($sformatf("state_ph%0d", ph), {29'd0, state}, {29'd0, state_of(ph)});
    check_val($sformatf("strobes_ph%0d_k%0d", ph, k), {19'd0, obs_strobes()},
              {19'd0, exp_strobes(ph, k, rdy, z)});
    check_val("retired", {24'd0, retired}, exp_ret);
    @(posedge clk);
    #1;
  endtask

  task automatic retire();
    exp_ret = (exp_ret + 1) % (1 << CW);
  endtask

  task automatic run_instr(input logic [10:0] opc, input int wf, input int wm, input logic z);
    int k;
    k = classify(opc);
    opcode = opc;
    for (int i = 0; i <= wf; i++) cycle(P_FETCH, k, (i == wf), z);
    cycle(P_DECODE, k, 1'($urandom % 2), z);
    if (k != K_ILL) begin
      cycle(P_EXEC, k, 1'($urandom % 2), z);
      if (k == K_CBZ || k == K_B) begin
        retire();
      end else if (k == K_LD || k == K_ST) begin
        for (int i = 0; i <= wm; i++) begin
          cycle(P_MEM, k, (i == wm), z);
        end
        if (k == K_ST) begin
          retire();
        end else begin
          cycle(P_WB, k, 1'($urandom % 2), z);
          retire();
        end
      end else begin
        cycle(P_WB, k, 1'($urandom % 2), z);
        retire();
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_state"}, {29'd0, state}, {29'd0, ST_IDLE});
    check_val({tag, "_strobes"}, {19'd0, obs_strobes()}, 32'd0);
    check_val({tag, "_retired"}, {24'd0, retired}, 32'd0);
  endtask

  initial begin
    logic [10:0] opc;
    int sel;
    pc_reset_n = 1'b0;
    opcode     = 11'h000;
    zero_alu   = 1'b0;
    mem_ready  = 1'b0;
    #1;
    check_reset_outputs("por");
    repeat (2) @(posedge clk);
    #1;
    pc_reset_n = 1'b1;
    cycle(P_IDLE, K_ILL, 1'b1, 1'b0);

    run_instr(11'h458, 0, 0, 1'b0);
    run_instr(11'h7C2, 0, 3, 1'b0);
    run_instr(11'h5A3, 0, 0, 1'b1);
    run_instr(11'h5A5, 1, 0, 1'b0);
    run_instr(11'h000, 0, 0, 1'b1);
    run_instr(11'h0B7, 2, 0, 1'b0);

    // Reset in the middle of a stalled store
    opcode = 11'h7C0;
    cycle(P_FETCH, K_ST, 1'b1, 1'b0);
    cycle(P_DECODE, K_ST, 1'b0, 1'b0);
    cycle(P_EXEC, K_ST, 1'b0, 1'b0);
    cycle(P_MEM, K_ST, 1'b0, 1'b0);
    #2;
    pc_reset_n = 1'b0;
    #1;
    exp_ret = 0;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    check_reset_outputs("inrst");
    pc_reset_n = 1'b1;
    cycle(P_IDLE, K_ILL, 1'b1, 1'b0);
    run_instr(11'h7C0, 0, 0, 1'b0);

    for (int n = 0; n < 500; n++) begin
      sel = int'($urandom % 8);
      case (sel)
        0: begin
          case ($urandom % 4)
            0: opc = 11'h458;
            1: opc = 11'h658;
            2: opc = 11'h450;
            default: opc = 11'h550;
          endcase
        end
        1: opc = 11'h7C2;
        2: opc = 11'h7C0;
        3: opc = {8'hB4, 3'($urandom)};
        4: opc = {6'h05, 5'($urandom)};
        default: opc = 11'($urandom);
      endcase
      run_instr(opc, int'($urandom % 3), int'($urandom % 4), 1'($urandom % 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
